clk_gen_core: RTL and testbench

//  Programmable multi-channel clock-divider core that feeds the tt_um_toniklippeo top level.
//  The top maps ui_in/uio_in onto the config handshake and clk_out/tick onto uo_out.

---
 rtl/clk_gen_pkg.sv | 29 ++
 rtl/clk_gen_core_if.sv | 29 ++
 rtl/clk_gen_chan.sv | 68 ++++++
 rtl/clk_gen_core.sv | 61 ++++++
 tb/tb_clk_gen_core.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/clk_gen_pkg.sv
// Shared constants, configuration record and high-time helper for the
// clk_gen multi-channel divider core.
package clk_gen_pkg;

   localparam int NUM_CH_DEF  = 2;
   localparam int DIV_W_DEF   = 8;
   // Divisors at or below this value switch a channel off.
   localparam int DIV_OFF_MAX = 1;

   typedef logic [DIV_W_DEF-1:0] div_t;
   typedef logic [DIV_W_DEF:0]   div_ext_t;

   typedef struct packed {
      div_t div;
      div_t high;
   } chan_cfg_t;

   // One bit wider than the fields so (div+1)>>1 stays exact at div = 2**DIV_W-1.
   function automatic div_ext_t high_eff(input div_t div, input div_t high);
      div_ext_t r;
      if (high == '0) begin
         r = ({1'b0, div} + div_ext_t'(1)) >> 1;
      end else begin
         r = {1'b0, high};
      end
      return r;
   endfunction

endpackage

// File: rtl/clk_gen_core_if.sv
// Configuration handshake between the pad-mapping top level and clk_gen_core.
interface clk_gen_core_if #(
   parameter int CH_W  = 1,
   parameter int DIV_W = 8
);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [DIV_W-1:0] cfg_div;
   logic [DIV_W-1:0] cfg_high;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_div,
      output cfg_high,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_div,
      input  cfg_high,
      output cfg_ready
   );

endinterface

// File: rtl/clk_gen_chan.sv
// One divider channel: shadow config, pending flag, period counter and
// registered clk_out/tick/active outputs.
module clk_gen_chan
   import clk_gen_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      en,
   input  logic      wr,
   input  chan_cfg_t wr_cfg,
   output logic      pending,
   output logic      clk_out,
   output logic      tick,
   output logic      active
);

   chan_cfg_t live;
   chan_cfg_t shadow;
   div_t      cnt;
   div_ext_t  last_cnt;
   div_ext_t  h_eff;
   logic      is_on;
   logic      run;
   logic      at_end;
   logic      apply;

   assign is_on    = live.div > div_t'(DIV_OFF_MAX);
   assign run      = is_on && en;
   assign last_cnt = {1'b0, live.div} - div_ext_t'(1);
   assign h_eff    = high_eff(live.div, live.high);
   assign at_end   = {1'b0, cnt} == last_cnt;
   // A stopped or off channel has no period boundary to wait for.
   assign apply    = pending && (!run || at_end);

   // NOTE: non-blocking assignments here so every flop samples the pre-edge
   // cnt/live values; blocking would let later lines see the updated count.
   always_ff @(posedge clk) begin
      if (rst) begin
         live    <= '0;
         shadow  <= '0;
         pending <= 1'b0;
         cnt     <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
         active  <= 1'b0;
      end else begin
         if (wr) begin
            shadow  <= wr_cfg;
            pending <= 1'b1;
         end else if (apply) begin
            pending <= 1'b0;
         end

         if (apply) begin
            live <= shadow;
            cnt  <= '0;
         end else if (run) begin
            cnt <= at_end ? '0 : cnt + div_t'(1);
         end

         // Outputs decode the pre-edge count, so they move in lockstep with cnt.
         clk_out <= run && ({1'b0, cnt} < h_eff);
         tick    <= run && (cnt == '0);
         active  <= is_on;
      end
   end

endmodule

// File: rtl/clk_gen_core.sv
// Multi-channel programmable clock divider: decodes the config handshake and
// fans it out to NUM_CH independent glitch-free divider channels.
module clk_gen_core
   import clk_gen_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int DIV_W  = DIV_W_DEF,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   clk_gen_core_if.slave       bus,
   output logic [NUM_CH-1:0]   clk_out,
   output logic [NUM_CH-1:0]   tick,
   output logic [NUM_CH-1:0]   active
);

   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] wr;
   logic              ready;
   logic [DIV_W-1:0]  div_in;
   logic [DIV_W-1:0]  high_in;
   chan_cfg_t         cfg_word;

   assign div_in   = bus.cfg_div;
   assign high_in  = bus.cfg_high;
   assign cfg_word = '{div: div_in, high: high_in};

   // Out-of-range channel indices match nothing: ready stays high and the
   // request is accepted and dropped.
   // NOTE: ready and wr get defaults before the loop so every path assigns
   // them and no latch is inferred.
   always_comb begin
      ready = 1'b1;
      wr    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (bus.cfg_ch == CH_W'(i)) begin
            ready = !pending[i];
            wr[i] = bus.cfg_valid && !pending[i];
         end
      end
   end

   assign bus.cfg_ready = ready;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_gen_chan u_chan (
         .clk     (clk),
         .rst     (rst),
         .en      (en),
         .wr      (wr[g]),
         .wr_cfg  (cfg_word),
         .pending (pending[g]),
         .clk_out (clk_out[g]),
         .tick    (tick[g]),
         .active  (active[g])
      );
   end

endmodule

// File: tb/tb_clk_gen_core.sv
// Directed, table-driven bench for clk_gen_core with two channels.
module tb_clk_gen_core;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] clk_out;
   logic [1:0] tick;
   logic [1:0] active;

   clk_gen_core_if #(.CH_W(1), .DIV_W(8)) bus ();

   clk_gen_core #(.NUM_CH(2), .DIV_W(8), .CH_W(1)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .bus     (bus),
      .clk_out (clk_out),
      .tick    (tick),
      .active  (active)
   );

   always #5 clk = ~clk;

   // One row per clock cycle: inputs held for the cycle, cfg_ready expected
   // before the edge, registered outputs expected after it. Bit 0 is ch0.
   typedef struct {
      logic       rst;
      logic       en;
      logic       vld;
      logic       ch;
      logic [7:0] div;
      logic [7:0] high;
      logic [1:0] clk_o;
      logic [1:0] tk;
      logic [1:0] act;
      logic       rdy;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input int idx,
                        input logic [7:0] got, input logic [7:0] exp_v);
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp_v);
      end
   endtask

   function automatic void add(input int r, input int e, input int vl, input int c,
                               input int d, input int h, input int co, input int tk,
                               input int ac, input int rd);
      vec_t v;
      v.rst   = (r != 0);
      v.en    = (e != 0);
      v.vld   = (vl != 0);
      v.ch    = (c != 0);
      v.div   = 8'(d);
      v.high  = 8'(h);
      v.clk_o = 2'(co);
      v.tk    = 2'(tk);
      v.act   = 2'(ac);
      v.rdy   = (rd != 0);
      vecs.push_back(v);
   endfunction

   task automatic run_vecs(input string name);
      for (int i = 0; i < vecs.size(); i++) begin
         rst           = vecs[i].rst;
         en            = vecs[i].en;
         bus.cfg_valid = vecs[i].vld;
         bus.cfg_ch    = vecs[i].ch;
         bus.cfg_div   = vecs[i].div;
         bus.cfg_high  = vecs[i].high;
         #1;
         check({name, ".ready"}, i, 8'(bus.cfg_ready), 8'(vecs[i].rdy));
         @(posedge clk);
         #1;
         check({name, ".clk_out"}, i, 8'(clk_out), 8'(vecs[i].clk_o));
         check({name, ".tick"},    i, 8'(tick),    8'(vecs[i].tk));
         check({name, ".active"},  i, 8'(active),  8'(vecs[i].act));
      end
      vecs.delete();
   endtask

   task automatic add_reset();
      add(1,1,0,0,0,0, 'b00,'b00,'b00,1);
      add(1,1,0,0,0,0, 'b00,'b00,'b00,1);
   endtask

   initial begin
      rst           = 1'b1;
      en            = 1'b1;
      bus.cfg_valid = 1'b0;
      bus.cfg_ch    = 1'b0;
      bus.cfg_div   = 8'd0;
      bus.cfg_high  = 8'd0;

      // Reset for 3 cycles, then 20 idle cycles with everything low.
      for (int i = 0; i < 3; i++)  add(1,1,0,0,0,0, 'b00,'b00,'b00,1);
      for (int i = 0; i < 20; i++) add(0,1,0,i%2,0,0, 'b00,'b00,'b00,1);
      run_vecs("reset_idle");

      // ch0 div=4 auto high: 1100 pattern starting two cycles after accept.
      add_reset();
      add(0,1,1,0,4,0, 'b00,'b00,'b00,1);
      add(0,1,0,0,0,0, 'b00,'b00,'b00,0);
      add(0,1,0,0,0,0, 'b01,'b01,'b01,1);
      add(0,1,0,0,0,0, 'b01,'b00,'b01,1);
      add(0,1,0,0,0,0, 'b00,'b00,'b01,1);
      add(0,1,0,0,0,0, 'b00,'b00,'b01,1);
      add(0,1,0,0,0,0, 'b01,'b01,'b01,1);
      add(0,1,0,0,0,0, 'b01,'b00,'b01,1);
      add(0,1,0,0,0,0, 'b00,'b00,'b01,1);
      add(0,1,0,0,0,0, 'b00,'b00,'b01,1);
      run_vecs("div4");

      // ch0 div=5 -> 11100; ch1 div=5 high=1 -> 10000; then ch1 high=9 -> constant 1.
      add_reset();
      add(0,1,1,0,5,0, 'b00,'b00,'b00,1);
      add(0,1,1,1,5,1, 'b00,'b00,'b00,1);
      add(0,1,0,1,0,0, 'b01,'b01,'b01,0);
      add(0,1,0,1,0,0, 'b11,'b10,'b11,1);
      add(0,1,0,1,0,0, 'b01,'b00,'b11,1);
      add(0,1,0,1,0,0, 'b00,'b00,'b11,1);
      add(0,1,0,1,0,0, 'b00,'b00,'b11,1);
      add(0,1,0,1,0,0, 'b01,'b01,'b11,1);
      add(0,1,0,1,0,0, 'b11,'b10,'b11,1);
      add(0,1,0,1,0,0, 'b01,'b00,'b11,1);
      add(0,1,1,1,5,9, 'b00,'b00,'b11,1);
      add(0,1,0,1,0,0, 'b00,'b00,'b11,0);
      add(0,1,0,1,0,0, 'b01,'b01,'b11,0);
      add(0,1,0,1,0,0, 'b11,'b10,'b11,1);
      add(0,1,0,1,0,0, 'b11,'b00,'b11,1);
      add(0,1,0,1,0,0, 'b10,'b00,'b11,1);
      add(0,1,0,1,0,0, 'b10,'b00,'b11,1);
      add(0,1,0,1,0,0, 'b11,'b01,'b11,1);
      add(0,1,0,1,0,0, 'b11,'b10,'b11,1);
      add(0,1,0,1,0,0, 'b11,'b00,'b11,1);
      run_vecs("div5_high");

      // ch0 div=8, rewrite div=3 at cnt=2: full 8-cycle period, then 110.
      // ch1 write inside the pending window is accepted immediately.
      add_reset();
      add(0,1,1,0,8,0, 'b00,'b00,'b00,1);
      add(0,1,0,0,0,0, 'b00,'b00,'b00,0);
      add(0,1,0,0,0,0, 'b01,'b01,'b01,1);
      add(0,1,0,0,0,0, 'b01,'b00,'b01,1);
      add(0,1,1,0,3,0, 'b01,'b00,'b01,1);
      add(0,1,0,0,0,0, 'b01,'b00,'b01,0);
      add(0,1,1,1,2,0, 'b00,'b00,'b01,1);
      add(0,1,0,0,0,0, 'b00,'b00,'b01,0);
      add(0,1,0,0,0,0, 'b10,'b10,'b11,0);
      add(0,1,0,0,0,0, 'b00,'b00,'b11,0);
      add(0,1,0,0,0,0, 'b11,'b11,'b11,1);
      add(0,1,0,0,0,0, 'b01,'b00,'b11,1);
      add(0,1,0,0,0,0, 'b10,'b10,'b11,1);
      add(0,1,0,0,0,0, 'b01,'b01,'b11,1);
      add(0,1,0,0,0,0, 'b11,'b10,'b11,1);
      add(0,1,0,0,0,0, 'b00,'b00,'b11,1);
      run_vecs("reconfig");

      // ch0 div=6, write div=1 mid-period: period completes, then all low.
      add_reset();
      add(0,1,1,0,6,0, 'b00,'b00,'b00,1);
      add(0,1,0,0,0,0, 'b00,'b00,'b00,0);
      add(0,1,0,0,0,0, 'b01,'b01,'b01,1);
      add(0,1,1,0,1,0, 'b01,'b00,'b01,1);
      add(0,1,0,0,0,0, 'b01,'b00,'b01,0);
      add(0,1,0,0,0,0, 'b00,'b00,'b01,0);
      add(0,1,0,0,0,0, 'b00,'b00,'b01,0);
      add(0,1,0,0,0,0, 'b00,'b00,'b01,0);
      add(0,1,0,0,0,0, 'b00,'b00,'b00,1);
      add(0,1,0,0,0,0, 'b00,'b00,'b00,1);
      run_vecs("switch_off");

      // en low at cnt=3 of div=8 for 5 cycles; ch1 configured while en is low
      // starts from 0 on resume; reset mid-period clears everything.
      add_reset();
      add(0,1,1,0,8,0, 'b00,'b00,'b00,1);
      add(0,1,0,0,0,0, 'b00,'b00,'b00,0);
      add(0,1,0,0,0,0, 'b01,'b01,'b01,1);
      add(0,1,0,0,0,0, 'b01,'b00,'b01,1);
      add(0,1,0,0,0,0, 'b01,'b00,'b01,1);
      add(0,0,1,1,2,0, 'b00,'b00,'b01,1);
      add(0,0,0,1,0,0, 'b00,'b00,'b01,0);
      add(0,0,0,1,0,0, 'b00,'b00,'b11,1);
      add(0,0,0,0,0,0, 'b00,'b00,'b11,1);
      add(0,0,0,0,0,0, 'b00,'b00,'b11,1);
      add(0,1,0,0,0,0, 'b11,'b10,'b11,1);
      add(0,1,0,0,0,0, 'b00,'b00,'b11,1);
      add(0,1,0,0,0,0, 'b10,'b10,'b11,1);
      add(0,1,0,0,0,0, 'b00,'b00,'b11,1);
      add(0,1,0,0,0,0, 'b10,'b10,'b11,1);
      add(0,1,0,0,0,0, 'b01,'b01,'b11,1);
      add(1,1,0,0,0,0, 'b00,'b00,'b00,1);
      add(0,1,0,0,0,0, 'b00,'b00,'b00,1);
      run_vecs("enable_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
